// File: rtl/fetch_sequencer_if.sv
// Loader stream, instruction-memory port and decode-side fetch signals of the fetch sequencer.
interface fetch_sequencer_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned IW = 9
);
  logic          load_valid;
  logic          load_ready;
  logic [IW-1:0] load_data;
  logic          load_last;
  logic          start;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [IW-1:0] mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [IW-1:0] mem_instr;
  logic          stall;
  logic          branch_valid;
  logic [AW-1:0] branch_target;
  logic [IW-1:0] instr_out;
  logic          instr_valid;
  logic [AW-1:0] instr_pc;
  logic          halted;
  logic [AW:0]   prog_len;

  modport slave (
    input  load_valid, load_data, load_last, start, mem_instr,
           stall, branch_valid, branch_target,
    output load_ready, mem_we, mem_waddr, mem_wdata, mem_addr,
           instr_out, instr_valid, instr_pc, halted, prog_len
  );

  modport master (
    output load_valid, load_data, load_last, start, mem_instr,
           stall, branch_valid, branch_target,
    input  load_ready, mem_we, mem_waddr, mem_wdata, mem_addr,
           instr_out, instr_valid, instr_pc, halted, prog_len
  );
endinterface

// File: rtl/fetch_sequencer.sv
// TinyChip fetch sequencer: boot-loads the instruction store from a
// valid/ready stream, then fetches sequentially with stall, branch redirect
// and halt when the PC runs past the loaded program.
module fetch_sequencer #(
  parameter int unsigned AW    = 8,
  parameter int unsigned IW    = 9,
  parameter int unsigned DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset,
  fetch_sequencer_if.slave  bus
);

  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HALT} state_t;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_pc, w_pc_nxt;
  logic [AW-1:0] r_wptr, w_wptr_nxt;
  logic [PW-1:0] r_prog_len, w_prog_len_nxt;
  logic [IW-1:0] r_instr_out, w_instr_out_nxt;
  logic [AW-1:0] r_instr_pc, w_instr_pc_nxt;
  logic          r_instr_valid, w_instr_valid_nxt;
  logic          r_halted, w_halted_nxt;

  logic w_load_ready;
  logic w_accept;
  logic w_restart;

  // Loader handshake; a beat arriving in IDLE/HALT always lands at address 0.
  assign w_load_ready = (r_state != S_RUN);
  assign w_accept     = bus.load_valid & w_load_ready;
  assign w_restart    = (r_state == S_IDLE) || (r_state == S_HALT);

  assign bus.load_ready  = w_load_ready;
  assign bus.mem_we      = w_accept;
  assign bus.mem_waddr   = w_restart ? '0 : r_wptr;
  assign bus.mem_wdata   = bus.load_data;
  assign bus.mem_addr    = r_pc[AW-1:0];
  assign bus.instr_out   = r_instr_out;
  assign bus.instr_valid = r_instr_valid;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.halted      = r_halted;
  assign bus.prog_len    = r_prog_len;

  // Next-state and next-register values for load, start and fetch.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_wptr_nxt        = r_wptr;
    w_prog_len_nxt    = r_prog_len;
    w_instr_out_nxt   = r_instr_out;
    w_instr_pc_nxt    = r_instr_pc;
    w_instr_valid_nxt = r_instr_valid;
    w_halted_nxt      = r_halted;

    case (r_state)
      S_IDLE, S_HALT: begin
        if (w_accept) begin
          w_wptr_nxt   = AW'(1);
          w_halted_nxt = 1'b0;
          if (bus.load_last) begin
            // Single-word program: load completes on its only beat.
            w_prog_len_nxt = PW'(1);
            w_state_nxt    = S_IDLE;
          end else begin
            w_prog_len_nxt = '0;
            w_state_nxt    = S_LOAD;
          end
        end else if (bus.start && (r_prog_len != '0)) begin
          w_pc_nxt          = '0;
          w_halted_nxt      = 1'b0;
          w_instr_valid_nxt = 1'b0;
          w_state_nxt       = S_RUN;
        end
      end

      S_LOAD: begin
        if (w_accept) begin
          w_wptr_nxt = r_wptr + AW'(1);
          if (bus.load_last || (r_wptr == AW'(DEPTH - 1))) begin
            w_prog_len_nxt = PW'(r_wptr) + PW'(1);
            w_state_nxt    = S_IDLE;
          end
        end
      end

      S_RUN: begin
        if (bus.branch_valid) begin
          // Redirect squashes the in-flight word even under stall.
          w_pc_nxt          = PW'(bus.branch_target);
          w_instr_valid_nxt = 1'b0;
        end else if (bus.stall) begin
          w_pc_nxt = r_pc;
        end else if (r_pc >= r_prog_len) begin
          // Covers both running off the end and branching beyond it.
          w_instr_valid_nxt = 1'b0;
          w_halted_nxt      = 1'b1;
          w_state_nxt       = S_HALT;
        end else begin
          w_instr_out_nxt   = bus.mem_instr;
          w_instr_pc_nxt    = r_pc[AW-1:0];
          w_instr_valid_nxt = 1'b1;
          w_pc_nxt          = r_pc + PW'(1);
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pc          <= '0;
      r_wptr        <= '0;
      r_prog_len    <= '0;
      r_instr_out   <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_wptr        <= w_wptr_nxt;
      r_prog_len    <= w_prog_len_nxt;
      r_instr_out   <= w_instr_out_nxt;
      r_instr_pc    <= w_instr_pc_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_halted      <= w_halted_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: bench-side instruction memory, a program-level
// reference model checked every cycle, and directed scenarios with literal expectations.
module tb_fetch_sequencer;

  localparam int AW    = 8;
  localparam int IW    = 9;
  localparam int DEPTH = 256;

  logic clk;
  logic reset;

  fetch_sequencer_if #(.AW(AW), .IW(IW)) bus ();

  fetch_sequencer #(.AW(AW), .IW(IW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: synchronous write, combinational read.
  logic [IW-1:0] bmem [DEPTH];
  always_ff @(posedge clk) begin
    if (bus.mem_we) bmem[bus.mem_waddr] <= bus.mem_wdata;
  end
  assign bus.mem_instr = bmem[bus.mem_addr];

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: what has been loaded, whether a program is executing,
  // and which word the decoder should be seeing.
  logic [IW-1:0] m_prog [DEPTH];
  bit            m_loading = 0;
  bit            m_running = 0;
  bit            m_halted  = 0;
  bit            m_valid   = 0;
  int            m_cnt     = 0;
  int            m_pc      = 0;
  int            m_prog_len = 0;
  logic [IW-1:0] m_out     = '0;
  int            m_ipc     = 0;

  task automatic model_step();
    if (reset) begin
      m_loading = 0; m_running = 0; m_halted = 0; m_valid = 0;
      m_cnt = 0; m_pc = 0; m_prog_len = 0; m_out = '0; m_ipc = 0;
    end else if (!m_running) begin
      if (bus.load_valid) begin
        if (!m_loading) begin
          m_cnt = 0; m_halted = 0; m_prog_len = 0;
        end
        m_prog[m_cnt] = bus.load_data;
        m_cnt++;
        if (bus.load_last || m_cnt == DEPTH) begin
          m_loading = 0; m_prog_len = m_cnt;
        end else begin
          m_loading = 1;
        end
      end else if (bus.start && !m_loading && m_prog_len != 0) begin
        m_running = 1; m_pc = 0; m_halted = 0; m_valid = 0;
      end
    end else begin
      if (bus.branch_valid) begin
        m_pc = int'(bus.branch_target); m_valid = 0;
      end else if (bus.stall) begin
        m_pc = m_pc;
      end else if (m_pc >= m_prog_len) begin
        m_valid = 0; m_halted = 1; m_running = 0;
      end else begin
        m_out = m_prog[m_pc]; m_ipc = m_pc; m_valid = 1; m_pc++;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    chk("instr_valid", bus.instr_valid, m_valid);
    chk("halted", bus.halted, m_halted);
    chk("prog_len", bus.prog_len, m_prog_len);
    chk("load_ready", bus.load_ready, !m_running);
    chk("mem_addr", bus.mem_addr, m_pc % DEPTH);
    chk("mem_we", bus.mem_we, bus.load_valid && !m_running);
    if (bus.load_valid && !m_running) begin
      chk("mem_waddr", bus.mem_waddr, m_loading ? m_cnt : 0);
      chk("mem_wdata", bus.mem_wdata, bus.load_data);
    end
    if (m_valid) begin
      chk("instr_out", bus.instr_out, m_out);
      chk("instr_pc", bus.instr_pc, m_ipc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [IW-1:0] d, input logic last, input int exp_addr);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_last  = last;
    #1;
    chk("beat_we", bus.mem_we, 1);
    chk("beat_waddr", bus.mem_waddr, exp_addr);
    tick();
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic run_to_halt(input string nm);
    for (int k = 0; k < 40 && !bus.halted; k++) tick();
    chk(nm, bus.halted, 1);
  endtask

  logic [IW-1:0] prog5 [5];

  initial begin
    prog5[0] = 9'h10F; prog5[1] = 9'h10F; prog5[2] = 9'h1A3;
    prog5[3] = 9'h0A9; prog5[4] = 9'h198;

    reset = 1'b1;
    bus.load_valid = 1'b0; bus.load_data = '0; bus.load_last = 1'b0;
    bus.start = 1'b0; bus.stall = 1'b0; bus.branch_valid = 1'b0;
    bus.branch_target = '0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // T1: reset state
    chk("t1_valid", bus.instr_valid, 0);
    chk("t1_halted", bus.halted, 0);
    chk("t1_prog_len", bus.prog_len, 0);
    chk("t1_ready", bus.load_ready, 1);
    chk("t1_we", bus.mem_we, 0);

    // T2: load five words then run to halt
    for (int i = 0; i < 5; i++) beat(prog5[i], i == 4, i);
    bus.load_valid = 1'b0; bus.load_last = 1'b0;
    chk("t2_prog_len", bus.prog_len, 5);
    do_start();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_ipc", bus.instr_pc, i);
      chk("t2_iout", bus.instr_out, prog5[i]);
    end
    tick();
    chk("t2_halted", bus.halted, 1);
    chk("t2_valid_off", bus.instr_valid, 0);

    // T3: stall while word 2 is presented
    do_start();
    tick(); tick(); tick();
    chk("t3_ipc2", bus.instr_pc, 2);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_hold_out", bus.instr_out, 9'h1A3);
      chk("t3_hold_addr", bus.mem_addr, 3);
      chk("t3_hold_valid", bus.instr_valid, 1);
    end
    bus.stall = 1'b0;
    tick();
    chk("t3_resume", bus.instr_pc, 3);
    run_to_halt("t3_halt");

    // T4: branch with stall at address 3
    do_start();
    tick(); tick(); tick();
    chk("t4_addr3", bus.mem_addr, 3);
    bus.branch_valid = 1'b1; bus.stall = 1'b1; bus.branch_target = 8'd1;
    tick();
    bus.branch_valid = 1'b0; bus.stall = 1'b0;
    chk("t4_squash", bus.instr_valid, 0);
    chk("t4_redirect", bus.mem_addr, 1);
    tick();
    chk("t4_ipc1", bus.instr_pc, 1);
    chk("t4_iout", bus.instr_out, 9'h10F);
    run_to_halt("t4_halt");

    // Branch beyond the program halts without fetching
    do_start();
    tick();
    bus.branch_valid = 1'b1; bus.branch_target = 8'd7;
    tick();
    bus.branch_valid = 1'b0;
    chk("oob_squash", bus.instr_valid, 0);
    chk("oob_not_yet", bus.halted, 0);
    tick();
    chk("oob_halted", bus.halted, 1);
    chk("oob_nofetch", bus.instr_valid, 0);

    // T5: full-depth load without load_last, then run to the end
    for (int i = 0; i < DEPTH; i++) beat(IW'((i * 37 + 5) % 512), 1'b0, i);
    bus.load_valid = 1'b0;
    chk("t5_prog_len", bus.prog_len, 256);
    chk("t5_ready", bus.load_ready, 1);
    do_start();
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 10) begin bus.load_valid = 1'b1; bus.start = 1'b1; end
      if (i == 13) begin bus.load_valid = 1'b0; bus.start = 1'b0; end
      tick();
    end
    chk("t5_last_ipc", bus.instr_pc, 255);
    chk("t5_last_out", bus.instr_out, (255 * 37 + 5) % 512);
    tick();
    chk("t5_halted", bus.halted, 1);
    chk("t5_nowrap_valid", bus.instr_valid, 0);
    tick();
    chk("t5_still_halted", bus.halted, 1);

    // T6: asynchronous reset mid-run
    do_start();
    tick(); tick(); tick();
    chk("t6_running", bus.instr_valid, 1);
    #3 reset = 1'b1;
    #1;
    chk("t6_valid", bus.instr_valid, 0);
    chk("t6_prog_len", bus.prog_len, 0);
    chk("t6_addr", bus.mem_addr, 0);
    tick();
    reset = 1'b0;
    do_start();
    tick();
    chk("t6_no_start_halted", bus.halted, 0);
    chk("t6_no_start_valid", bus.instr_valid, 0);
    chk("t6_ready", bus.load_ready, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
